// File: rtl/rca_config.sv
// Shared configuration for the RCA grid I/O port: mode encoding and default sizes.
package rca_config;

  // Datapath mode of the grid I/O port; encoding 2'b11 is reserved and behaves as BYPASS.
  typedef enum logic [1:0] {
    IO_BYPASS  = 2'b00,
    IO_PIPE    = 2'b01,
    IO_CAPTURE = 2'b10
  } io_mode_t;

  localparam int IO_DATA_W     = 32;
  localparam int IO_FIFO_DEPTH = 8;

  // Map the raw 2-bit mode field onto io_mode_t, folding the reserved code into BYPASS.
  function automatic io_mode_t io_mode_decode(input logic [1:0] raw);
    case (raw)
      2'b01:   return IO_PIPE;
      2'b10:   return IO_CAPTURE;
      default: return IO_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/rca_io_fifo.sv
// Circular capture buffer for the grid I/O port: show-ahead read, separate occupancy
// counter, synchronous flush. Reports which push/pop requests were accepted.
module rca_io_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     push_ok_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop_ok;
  logic              push_ok;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign push_ok_o = push_ok;

  // Accept logic and next-state of pointers/count; a pop frees a slot for a same-cycle push.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the block infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_ok   = pop_i & ~empty_o & ~flush_i;
    push_ok  = push_i & ~flush_i & (~full_o | pop_ok);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  // NOTE: the data array is deliberately not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/grid_io_port.sv
// RCA grid I/O port: selectable BYPASS / PIPE / CAPTURE datapath between a grid lane and the
// writeback network, with FIFO status and sticky overflow/underflow flags.
// Optional build macro RCA_IO_DROP_CNT_EN adds a saturating 16-bit dropped-push counter.
module grid_io_port
  import rca_config::*;
#(
  parameter int DATA_W     = IO_DATA_W,
  parameter int FIFO_DEPTH = IO_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  io_mode,
  input  logic                        data_valid_in,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        fifo_pop,
  input  logic                        fifo_flush,
  input  logic                        err_clr,
  output logic                        data_valid_out,
  output logic [DATA_W-1:0]           data_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic                        overflow_err,
  output logic                        underflow_err
`ifdef RCA_IO_DROP_CNT_EN
  ,
  output logic [15:0]                 drop_count
`endif
);

  io_mode_t          mode;
  logic              push_req;
  logic              push_ok;
  logic              overflow_evt;
  logic              underflow_evt;
  logic [DATA_W-1:0] fifo_rdata;

  logic              pipe_valid_q, pipe_valid_d;
  logic [DATA_W-1:0] pipe_data_q, pipe_data_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  assign mode     = io_mode_decode(io_mode);
  assign push_req = data_valid_in & (mode == IO_CAPTURE);

  rca_io_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push_req),
    .pop_i     (fifo_pop),
    .flush_i   (fifo_flush),
    .wdata_i   (data_in),
    .rdata_o   (fifo_rdata),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .push_ok_o (push_ok)
  );

  // Error events; a flush cancels the same-cycle push/pop, so neither can raise a flag.
  always_comb begin
    overflow_evt  = push_req & ~push_ok & ~fifo_flush;
    underflow_evt = fifo_pop & fifo_empty & ~fifo_flush;
  end

  // Next state of pipe registers and sticky flags; an error event beats err_clr.
  always_comb begin
    pipe_valid_d = (mode == IO_PIPE) & data_valid_in;
    pipe_data_d  = pipe_data_q;
    if ((mode == IO_PIPE) && data_valid_in) pipe_data_d = data_in;
    overflow_d   = overflow_evt  | (overflow_q  & ~err_clr);
    underflow_d  = underflow_evt | (underflow_q & ~err_clr);
  end

  // Pipe and error-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid_q <= 1'b0;
      pipe_data_q  <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      pipe_valid_q <= pipe_valid_d;
      pipe_data_q  <= pipe_data_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Output mux selected by the current mode.
  always_comb begin
    data_valid_out = data_valid_in;
    data_out       = data_in;
    case (mode)
      IO_PIPE: begin
        data_valid_out = pipe_valid_q;
        data_out       = pipe_data_q;
      end
      IO_CAPTURE: begin
        data_valid_out = ~fifo_empty;
        data_out       = fifo_rdata;
      end
      default: begin
        data_valid_out = data_valid_in;
        data_out       = data_in;
      end
    endcase
  end

  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

`ifdef RCA_IO_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of dropped pushes; a drop in the clearing cycle restarts the count at 1.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (err_clr) begin
      drop_cnt_d = overflow_evt ? 16'd1 : 16'd0;
    end else if (overflow_evt && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_grid_io_port.sv
// Directed self-checking bench for grid_io_port (DATA_W=32, FIFO_DEPTH=8).
module tb_grid_io_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  io_mode;
  logic        data_valid_in;
  logic [31:0] data_in;
  logic        fifo_pop;
  logic        fifo_flush;
  logic        err_clr;
  logic        data_valid_out;
  logic [31:0] data_out;
  logic [3:0]  fifo_count;
  logic        fifo_full;
  logic        fifo_empty;
  logic        overflow_err;
  logic        underflow_err;
`ifdef RCA_IO_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  int n_vec = 0;
  int n_mis = 0;

  localparam logic [1:0] M_BYP = 2'b00;
  localparam logic [1:0] M_PIPE = 2'b01;
  localparam logic [1:0] M_CAP = 2'b10;
  localparam logic [1:0] M_RSV = 2'b11;

  grid_io_port #(.DATA_W(32), .FIFO_DEPTH(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .io_mode        (io_mode),
    .data_valid_in  (data_valid_in),
    .data_in        (data_in),
    .fifo_pop       (fifo_pop),
    .fifo_flush     (fifo_flush),
    .err_clr        (err_clr),
    .data_valid_out (data_valid_out),
    .data_out       (data_out),
    .fifo_count     (fifo_count),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .overflow_err   (overflow_err),
    .underflow_err  (underflow_err)
`ifdef RCA_IO_DROP_CNT_EN
    ,
    .drop_count     (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    data_valid_in = 1'b0;
    fifo_pop      = 1'b0;
    fifo_flush    = 1'b0;
    err_clr       = 1'b0;
  endtask

  logic [31:0] exp_drain [8];

  initial begin
    rst_n   = 1'b0;
    io_mode = M_BYP;
    data_in = 32'h0;
    idle_inputs();
    #2;
    // Reset state
    check("rst_count", fifo_count, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_ovf", overflow_err, 0);
    check("rst_unf", underflow_err, 0);
    io_mode = M_PIPE; data_valid_in = 1'b1; #1;
    check("rst_pipe_valid", data_valid_out, 0);
    io_mode = M_BYP; #1;
    check("rst_byp_valid", data_valid_out, 1);
    data_valid_in = 1'b0;
    #2 rst_n = 1'b1;
    tick();

    // 1: BYPASS is combinational
    io_mode = M_BYP; data_in = 32'hDEADBEEF; data_valid_in = 1'b1; #1;
    check("byp_data", data_out, 32'hDEADBEEF);
    check("byp_valid", data_valid_out, 1);
    data_valid_in = 1'b0; #1;
    check("byp_valid0", data_valid_out, 0);
    io_mode = M_RSV; data_in = 32'h1234; data_valid_in = 1'b1; #1;
    check("rsv_data", data_out, 32'h1234);
    check("rsv_valid", data_valid_out, 1);
    tick();

    // 2: PIPE, one cycle latency; first cycle after entry is invalid
    io_mode = M_PIPE; data_valid_in = 1'b0;
    tick();
    check("pipe_entry_valid", data_valid_out, 0);
    for (int i = 1; i <= 3; i++) begin
      data_in = 32'(i); data_valid_in = 1'b1;
      #1;
      check("pipe_not_yet", data_out, 32'(i - 1));
      tick();
      check("pipe_data", data_out, 32'(i));
      check("pipe_valid", data_valid_out, 1);
    end
    data_in = 32'h9; data_valid_in = 1'b0;
    tick();
    check("pipe_gap_valid", data_valid_out, 0);
    check("pipe_gap_hold", data_out, 32'h3);

    // 3: CAPTURE, overfill with 0..9
    io_mode = M_CAP; data_valid_in = 1'b0; #1;
    check("cap_empty_valid", data_valid_out, 0);
    for (int i = 0; i < 10; i++) begin
      data_in = 32'(i); data_valid_in = 1'b1;
      tick();
    end
    data_valid_in = 1'b0; #1;
    check("cap_count", fifo_count, 8);
    check("cap_full", fifo_full, 1);
    check("cap_ovf", overflow_err, 1);
    check("cap_unf", underflow_err, 0);
    check("cap_valid", data_valid_out, 1);
`ifdef RCA_IO_DROP_CNT_EN
    check("cap_drops", drop_count, 2);
`endif
    fifo_pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("cap_pop_data", data_out, 32'(i));
      tick();
    end
    fifo_pop = 1'b0; #1;
    check("cap_drained_empty", fifo_empty, 1);
    check("cap_drained_valid", data_valid_out, 0);
    check("cap_drained_unf", underflow_err, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("errclr_ovf", overflow_err, 0);
`ifdef RCA_IO_DROP_CNT_EN
    check("errclr_drops", drop_count, 0);
`endif

    // 4: full + simultaneous push/pop keeps count, no overflow
    for (int i = 0; i < 8; i++) begin
      data_in = 32'h10 + 32'(i); data_valid_in = 1'b1;
      tick();
    end
    data_in = 32'hAA; data_valid_in = 1'b1; fifo_pop = 1'b1;
    tick();
    idle_inputs();
    check("fullpp_count", fifo_count, 8);
    check("fullpp_ovf", overflow_err, 0);
    check("fullpp_full", fifo_full, 1);
    for (int i = 0; i < 7; i++) exp_drain[i] = 32'h11 + 32'(i);
    exp_drain[7] = 32'hAA;
    fifo_pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("fullpp_drain", data_out, exp_drain[i]);
      tick();
    end
    fifo_pop = 1'b0;
    check("fullpp_empty", fifo_empty, 1);

    // 5: pop on empty with same-cycle push
    fifo_pop = 1'b1; data_valid_in = 1'b1; data_in = 32'h55;
    tick();
    idle_inputs();
    check("unf_flag", underflow_err, 1);
    check("unf_count", fifo_count, 1);
    check("unf_head", data_out, 32'h55);
    check("unf_valid", data_valid_out, 1);
    fifo_pop = 1'b1;
    tick();
    err_clr = 1'b1;
    tick();
    check("errclr_loses", underflow_err, 1);
    fifo_pop = 1'b0;
    tick();
    err_clr = 1'b0;
    check("errclr_clears", underflow_err, 0);

    // FIFO contents survive a mode change and drain by pop in another mode
    for (int i = 0; i < 2; i++) begin
      data_in = 32'h21 + 32'(i); data_valid_in = 1'b1;
      tick();
    end
    data_valid_in = 1'b0; io_mode = M_PIPE; fifo_pop = 1'b1;
    tick();
    fifo_pop = 1'b0; io_mode = M_CAP; #1;
    check("modechg_count", fifo_count, 1);
    check("modechg_head", data_out, 32'h22);
    fifo_pop = 1'b1;
    tick();
    fifo_pop = 1'b0;

    // 6: flush with concurrent push
    for (int i = 0; i < 5; i++) begin
      data_in = 32'h30 + 32'(i); data_valid_in = 1'b1;
      tick();
    end
    data_valid_in = 1'b0; #1;
    check("pre_flush_count", fifo_count, 5);
    data_in = 32'h77; data_valid_in = 1'b1; fifo_flush = 1'b1;
    tick();
    idle_inputs();
    check("flush_count", fifo_count, 0);
    check("flush_empty", fifo_empty, 1);
    check("flush_ovf", overflow_err, 0);
    check("flush_unf", underflow_err, 0);

    // Reset mid-burst clears everything asynchronously
    fifo_pop = 1'b1;
    tick();
    fifo_pop = 1'b0;
    check("pre_rst_unf", underflow_err, 1);
    for (int i = 0; i < 3; i++) begin
      data_in = 32'h40 + 32'(i); data_valid_in = 1'b1;
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_count", fifo_count, 0);
    check("midrst_empty", fifo_empty, 1);
    check("midrst_full", fifo_full, 0);
    check("midrst_valid", data_valid_out, 0);
    check("midrst_unf", underflow_err, 0);
    check("midrst_ovf", overflow_err, 0);
    io_mode = M_PIPE; #1;
    check("midrst_pipe_valid", data_valid_out, 0);
    check("midrst_pipe_data", data_out, 0);
    io_mode = M_BYP; #1;
    check("midrst_byp_valid", data_valid_out, 1);
    idle_inputs();
    #2 rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
